// File: rtl/program_memory_loadable_if.sv
// Fetch and program-load bus of the loadable instruction memory.
// master drives requests and load words; slave is the memory.
interface program_memory_loadable_if #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 16
);
   logic                  fetch_en;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  data_valid;
   logic                  load_start;
   logic                  load_valid;
   logic [DATA_WIDTH-1:0] load_data;
   logic                  load_last;
   logic                  load_ready;
   logic                  load_done;
   logic [ADDR_WIDTH:0]   load_count;
   logic                  busy;

   modport master (
      output fetch_en,
      output addr,
      input  data_out,
      input  data_valid,
      output load_start,
      output load_valid,
      output load_data,
      output load_last,
      input  load_ready,
      input  load_done,
      input  load_count,
      input  busy
   );

   modport slave (
      input  fetch_en,
      input  addr,
      output data_out,
      output data_valid,
      input  load_start,
      input  load_valid,
      input  load_data,
      input  load_last,
      output load_ready,
      output load_done,
      output load_count,
      output busy
   );
endinterface

// File: rtl/program_memory_loadable.sv
// Run-time loadable instruction memory: registered fetch port,
// sequential program load, zero-fill of unused words, power-on clear.
module program_memory_loadable #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 16
) (
   input  logic clk,
   input  logic rst_n,
   program_memory_loadable_if.slave bus
);
   localparam int SIZE = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(SIZE - 1);

   typedef enum logic [1:0] {
      PCLR,
      IDLE,
      LOAD,
      CLEAR
   } state_t;

   state_t                state;
   state_t                state_n;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] wr_ptr_n;
   logic [ADDR_WIDTH:0]   cnt;
   logic [ADDR_WIDTH:0]   cnt_n;
   logic                  done;
   logic                  done_n;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_wd;
   logic                  accept;
   logic                  at_end;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_q;
   logic                  rv_q;

   logic [DATA_WIDTH-1:0] mem [SIZE];

   assign bus.load_ready = (state == LOAD);
   assign bus.busy       = (state != IDLE);
   assign bus.load_done  = done;
   assign bus.load_count = cnt;
   assign bus.data_out   = rd_q;
   assign bus.data_valid = rv_q;

   assign accept = bus.load_valid & bus.load_ready;
   assign at_end = (wr_ptr == LAST);
   // Reads only in IDLE, so a fetch never races a write.
   assign rd_en  = bus.fetch_en & (state == IDLE);

   always_comb begin
      state_n  = state;
      wr_ptr_n = wr_ptr;
      cnt_n    = cnt;
      done_n   = 1'b0;
      mem_we   = 1'b0;
      mem_wd   = '0;
      unique case (state)
         PCLR: begin
            mem_we = 1'b1;
            if (at_end) state_n = IDLE;
            else wr_ptr_n = wr_ptr + 1'b1;
         end
         IDLE: begin
            if (bus.load_start) begin
               state_n  = LOAD;
               wr_ptr_n = '0;
               cnt_n    = '0;
            end
         end
         LOAD: begin
            if (accept) begin
               mem_we = 1'b1;
               mem_wd = bus.load_data;
               cnt_n  = cnt + 1'b1;
               // The last slot ends the load whatever load_last says.
               if (at_end) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end else begin
                  wr_ptr_n = wr_ptr + 1'b1;
                  if (bus.load_last) state_n = CLEAR;
               end
            end
         end
         CLEAR: begin
            mem_we = 1'b1;
            if (at_end) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end else begin
               wr_ptr_n = wr_ptr + 1'b1;
            end
         end
         default: begin
            state_n  = PCLR;
            wr_ptr_n = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= PCLR;
         wr_ptr <= '0;
         cnt    <= '0;
         done   <= 1'b0;
      end else begin
         state  <= state_n;
         wr_ptr <= wr_ptr_n;
         cnt    <= cnt_n;
         done   <= done_n;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_ptr] <= mem_wd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q <= '0;
         rv_q <= 1'b0;
      end else begin
         rv_q <= rd_en;
         if (rd_en) rd_q <= mem[bus.addr];
      end
   end
endmodule

// File: tb/tb_program_memory_loadable.sv
// Scoreboard bench for program_memory_loadable (SIZE = 8).
// Expected fetch data comes from an array model of the loaded program.
module tb_program_memory_loadable;
   localparam int AW   = 3;
   localparam int DW   = 16;
   localparam int SIZE = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   program_memory_loadable_if #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW)
   ) m ();

   program_memory_loadable #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (m)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;
   logic [DW-1:0] model [SIZE];
   logic [DW-1:0] prog [$];
   logic [DW-1:0] exp_q [$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, want %0h", nm, got, exp);
   endtask

   // Loaded words first, zero everywhere else.
   task automatic apply_model(input int n);
      for (int i = 0; i < SIZE; i++)
         model[i] = (i < n) ? prog[i] : '0;
   endtask

   task automatic fetch(input int a);
      m.addr     = AW'(a);
      m.fetch_en = 1'b1;
      exp_q.push_back(model[a]);
      tick();
      m.fetch_en = 1'b0;
   endtask

   task automatic wait_idle(input bit noise, output int cyc, output int dn);
      cyc = 0;
      dn  = 0;
      while (m.busy && cyc < 100) begin
         m.fetch_en   = noise & 1'($urandom_range(0, 1));
         m.load_start = noise & 1'($urandom_range(0, 1));
         m.addr       = AW'($urandom_range(0, SIZE - 1));
         if (m.load_done) dn++;
         tick();
         cyc++;
         if (noise) chk("dv_busy", 32'(m.data_valid), 0);
      end
      m.fetch_en   = 1'b0;
      m.load_start = 1'b0;
   endtask

   task automatic load_prog(input bit use_last, input int gap,
                            input bit rnd, input bit noise,
                            input bit vs_start);
      int n;
      int g;
      int cyc;
      int dn;
      n = prog.size();
      chk("ready_idle", 32'(m.load_ready), 0);
      m.load_start = 1'b1;
      m.load_valid = vs_start;
      m.load_data  = 16'hDEAD;
      m.load_last  = 1'b0;
      tick();
      m.load_start = 1'b0;
      m.load_valid = 1'b0;
      chk("count_start", 32'(m.load_count), 0);
      for (int i = 0; i < n; i++) begin
         g = (i == 0) ? 0 : (rnd ? $urandom_range(0, gap) : gap);
         for (int j = 0; j < g; j++) begin
            m.load_last  = 1'($urandom_range(0, 1));
            m.load_start = noise & 1'($urandom_range(0, 1));
            m.fetch_en   = noise;
            tick();
            chk("dv_load", 32'(m.data_valid), 0);
         end
         m.load_valid = 1'b1;
         m.load_data  = prog[i];
         m.load_last  = use_last && (i == n - 1);
         m.load_start = noise & 1'($urandom_range(0, 1));
         m.fetch_en   = noise & 1'($urandom_range(0, 1));
         chk("ready_load", 32'(m.load_ready), 1);
         tick();
         m.load_valid = 1'b0;
         m.load_last  = 1'b0;
         m.load_start = 1'b0;
         m.fetch_en   = 1'b0;
         chk("count_acc", 32'(m.load_count), 32'(i + 1));
      end
      wait_idle(noise, cyc, dn);
      chk("clear_cycles", 32'(cyc), 32'((n >= SIZE) ? 0 : SIZE - n));
      chk("done_early", 32'(dn), 0);
      chk("done_pulse", 32'(m.load_done), 1);
      chk("count_final", 32'(m.load_count), 32'(n));
      tick();
      chk("done_drop", 32'(m.load_done), 0);
      apply_model(n);
   endtask

   initial begin
      int cyc;
      int dn;
      int n;
      m.fetch_en   = 1'b0;
      m.addr       = '0;
      m.load_start = 1'b0;
      m.load_valid = 1'b0;
      m.load_data  = '0;
      m.load_last  = 1'b0;

      fork
         forever begin
            @(negedge clk);
            if (m.data_valid === 1'b1) begin
               total_cnt++;
               if (exp_q.size() == 0) begin
                  $display("FAIL sb_unexpected: got data_valid with data %0h, want none",
                           m.data_out);
               end else begin
                  logic [DW-1:0] e;
                  e = exp_q.pop_front();
                  if (m.data_out === e) pass_cnt++;
                  else $display("FAIL sb_data: got %0h, want %0h", m.data_out, e);
               end
            end
         end
      join_none

      // power-on clear
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dout", 32'(m.data_out), 0);
      chk("rst_dv", 32'(m.data_valid), 0);
      chk("rst_done", 32'(m.load_done), 0);
      chk("rst_count", 32'(m.load_count), 0);
      chk("rst_busy", 32'(m.busy), 1);
      chk("rst_ready", 32'(m.load_ready), 0);
      rst_n = 1'b1;
      wait_idle(1'b0, cyc, dn);
      chk("pclr_cycles", 32'(cyc), 8);
      chk("pclr_done", 32'(dn + int'(m.load_done)), 0);
      prog.delete();
      apply_model(0);
      for (int a = 0; a < SIZE; a++) fetch(a);

      // three words with load_last, clear of the rest
      prog = '{16'hB203, 16'hB305, 16'h0464};
      load_prog(1'b1, 0, 1'b0, 1'b0, 1'b0);
      fetch(1);
      fetch(2);
      fetch(5);
      fetch(0);

      // full load without load_last; stray load_valid with load_start
      prog.delete();
      for (int i = 0; i < SIZE; i++) prog.push_back(DW'(16'h1000 + i));
      load_prog(1'b0, 0, 1'b0, 1'b0, 1'b1);
      fetch(7);
      fetch(0);

      // backpressure with busy-state noise
      prog = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
      load_prog(1'b1, 2, 1'b0, 1'b1, 1'b0);
      for (int a = 0; a < SIZE; a++) fetch(a);

      // reset in the middle of a load
      fetch(0);
      m.load_start = 1'b1;
      tick();
      m.load_start = 1'b0;
      m.load_valid = 1'b1;
      m.load_data  = 16'h5555;
      tick();
      m.load_data  = 16'hAAAA;
      tick();
      m.load_valid = 1'b0;
      chk("mid_count", 32'(m.load_count), 2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_dout", 32'(m.data_out), 0);
      chk("mid_rst_dv", 32'(m.data_valid), 0);
      chk("mid_rst_count", 32'(m.load_count), 0);
      chk("mid_rst_busy", 32'(m.busy), 1);
      tick();
      rst_n = 1'b1;
      wait_idle(1'b0, cyc, dn);
      chk("re_pclr_cycles", 32'(cyc), 8);
      prog.delete();
      apply_model(0);
      fetch(0);
      fetch(1);

      // random programs, gaps, noise and fetches
      for (int it = 0; it < 25; it++) begin
         n = $urandom_range(1, SIZE);
         prog.delete();
         for (int i = 0; i < n; i++) prog.push_back(DW'($urandom));
         load_prog((n < SIZE) ? 1'b1 : 1'($urandom_range(0, 1)),
                   2, 1'b1, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
         for (int k = 0; k < 6; k++) begin
            fetch($urandom_range(0, SIZE - 1));
            if ($urandom_range(0, 1) == 1) tick();
         end
      end

      repeat (3) tick();
      chk("sb_empty", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
